// File: rtl/ipd_multicanal.sv
// Multi-channel I-PD / PID controller. One signed multiplier is time-shared
// across the P, I and D products of every channel, in channel order.
module ipd_multicanal #(
   parameter int W    = 19,
   parameter int F    = 8,
   parameter int N_CH = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                modo,
   input  logic [W-1:0]        kp,
   input  logic [W-1:0]        ki,
   input  logic [W-1:0]        kd,
   input  logic [N_CH*W-1:0]   referencia,
   input  logic [N_CH*W-1:0]   y_k,
   output logic [N_CH*W-1:0]   salida_IPD,
   output logic [N_CH*W-1:0]   prop,
   output logic [N_CH*W-1:0]   integral,
   output logic [N_CH*W-1:0]   derivativa,
   output logic [N_CH-1:0]     sat_flag,
   output logic                ocupado,
   output logic                listo
);

   typedef enum logic [2:0] {IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUMA} state_t;

   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_CH - 1);
   localparam logic signed [2*W:0] MAXL = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] MINL = {{(W+2){1'b1}}, {(W-1){1'b0}}};

   state_t                state_q;
   logic [IW-1:0]         idx_q;
   logic                  modo_q, ocupado_q, listo_q;
   logic signed [W-1:0]   kp_q, ki_q, kd_q;
   logic signed [W-1:0]   r_q [N_CH];
   logic signed [W-1:0]   y_q [N_CH];
   logic signed [W:0]     e_q;
   logic signed [W-1:0]   p_q, kie_q, d_q;
   logic signed [W-1:0]   iprev_q [N_CH];
   logic signed [W-1:0]   yprev_q [N_CH];
   logic signed [W:0]     eprev_q [N_CH];
   logic [N_CH-1:0]       first_q;
   logic signed [W-1:0]   u_q   [N_CH];
   logic signed [W-1:0]   pOut_q [N_CH];
   logic signed [W-1:0]   iOut_q [N_CH];
   logic signed [W-1:0]   dOut_q [N_CH];
   logic [N_CH-1:0]       sat_q;

   logic signed [W-1:0]   mulA;
   logic signed [W:0]     mulB;
   logic signed [2*W:0]   prod, prodSh;
   logic signed [W:0]     yExt, yPrevExt;
   logic signed [W+1:0]   eDiff;
   logic signed [W:0]     itmp;
   logic signed [W+2:0]   uSum;
   logic signed [2*W:0]   uWide, itmpWide;
   logic                  clipHi, clipLo, hold;
   logic [IW-1:0]         nextIdx;

   function automatic logic signed [W-1:0] satW(input logic signed [2*W:0] v);
      if (v > MAXL)
         satW = {1'b0, {(W-1){1'b1}}};
      else if (v < MINL)
         satW = {1'b1, {(W-1){1'b0}}};
      else
         satW = v[W-1:0];
   endfunction

   function automatic logic signed [W:0] errOf(input logic signed [W-1:0] r,
                                               input logic signed [W-1:0] y);
      errOf = {r[W-1], r} - {y[W-1], y};
   endfunction

   assign yExt     = {y_q[idx_q][W-1], y_q[idx_q]};
   assign yPrevExt = {yprev_q[idx_q][W-1], yprev_q[idx_q]};
   assign eDiff    = {e_q[W], e_q} - {eprev_q[idx_q][W], eprev_q[idx_q]};
   assign nextIdx  = idx_q + 1'b1;

   // Operands are sign-extended by hand so the unsigned product keeps the low 2W+1 bits exact.
   assign prod   = {{(W+1){mulA[W-1]}}, mulA} * {{W{mulB[W]}}, mulB};
   assign prodSh = prod >>> F;

   always_comb begin
      mulA = kp_q;
      mulB = '0;
      case (state_q)
         MUL_P: begin
            mulA = kp_q;
            mulB = modo_q ? e_q : -yExt;
         end
         MUL_I: begin
            mulA = ki_q;
            mulB = e_q;
         end
         MUL_D: begin
            mulA = kd_q;
            if (modo_q)
               mulB = (eDiff[W+1] != eDiff[W]) ? {eDiff[W+1], {W{~eDiff[W+1]}}} : eDiff[W:0];
            else
               mulB = yPrevExt - yExt;
         end
         default: ;
      endcase
   end

   // The clip test uses the unsaturated integral so windup is visible in u.
   assign itmp     = {iprev_q[idx_q][W-1], iprev_q[idx_q]} + {kie_q[W-1], kie_q};
   assign uSum     = {{2{itmp[W]}}, itmp} + {{3{p_q[W-1]}}, p_q} + {{3{d_q[W-1]}}, d_q};
   assign uWide    = {{(W-2){uSum[W+2]}}, uSum};
   assign itmpWide = {{W{itmp[W]}}, itmp};
   assign clipHi   = (uWide > MAXL);
   assign clipLo   = (uWide < MINL);
   assign hold     = (clipHi && !kie_q[W-1] && (kie_q != '0)) || (clipLo && kie_q[W-1]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         modo_q    <= 1'b0;
         ocupado_q <= 1'b0;
         listo_q   <= 1'b0;
         kp_q      <= '0;
         ki_q      <= '0;
         kd_q      <= '0;
         e_q       <= '0;
         p_q       <= '0;
         kie_q     <= '0;
         d_q       <= '0;
         first_q   <= '1;
         sat_q     <= '0;
         for (int c = 0; c < N_CH; c++) begin
            r_q[c]     <= '0;
            y_q[c]     <= '0;
            iprev_q[c] <= '0;
            yprev_q[c] <= '0;
            eprev_q[c] <= '0;
            u_q[c]     <= '0;
            pOut_q[c]  <= '0;
            iOut_q[c]  <= '0;
            dOut_q[c]  <= '0;
         end
      end else begin
         listo_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  for (int c = 0; c < N_CH; c++) begin
                     r_q[c] <= referencia[c*W +: W];
                     y_q[c] <= y_k[c*W +: W];
                  end
                  kp_q      <= kp;
                  ki_q      <= ki;
                  kd_q      <= kd;
                  modo_q    <= modo;
                  ocupado_q <= 1'b1;
                  state_q   <= LOAD;
               end
            end
            LOAD: begin
               idx_q   <= '0;
               e_q     <= errOf(r_q[0], y_q[0]);
               state_q <= MUL_P;
            end
            MUL_P: begin
               p_q     <= satW(prodSh);
               state_q <= MUL_I;
            end
            MUL_I: begin
               kie_q   <= satW(prodSh);
               state_q <= MUL_D;
            end
            MUL_D: begin
               d_q     <= first_q[idx_q] ? '0 : satW(prodSh);
               state_q <= SUMA;
            end
            SUMA: begin
               u_q[idx_q]     <= satW(uWide);
               sat_q[idx_q]   <= clipHi | clipLo;
               pOut_q[idx_q]  <= p_q;
               iOut_q[idx_q]  <= satW(itmpWide);
               dOut_q[idx_q]  <= d_q;
               yprev_q[idx_q] <= y_q[idx_q];
               eprev_q[idx_q] <= e_q;
               first_q[idx_q] <= 1'b0;
               if (!hold)
                  iprev_q[idx_q] <= satW(itmpWide);
               if (idx_q == LAST) begin
                  listo_q   <= 1'b1;
                  ocupado_q <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  idx_q   <= nextIdx;
                  e_q     <= errOf(r_q[nextIdx], y_q[nextIdx]);
                  state_q <= MUL_P;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign salida_IPD[g*W +: W] = u_q[g];
      assign prop[g*W +: W]       = pOut_q[g];
      assign integral[g*W +: W]   = iOut_q[g];
      assign derivativa[g*W +: W] = dOut_q[g];
      assign sat_flag[g]          = sat_q[g];
   end

   assign ocupado = ocupado_q;
   assign listo   = listo_q;

endmodule

// File: tb/tb_ipd_multicanal.sv
// Directed testbench for ipd_multicanal: hand-computed Q11.8 expectations
// checked with immediate assertions at each step.
module tb_ipd_multicanal;

   localparam int W    = 19;
   localparam int F    = 8;
   localparam int N_CH = 2;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                enable = 1'b0;
   logic                modo = 1'b0;
   logic [W-1:0]        kp = '0;
   logic [W-1:0]        ki = '0;
   logic [W-1:0]        kd = '0;
   logic [N_CH*W-1:0]   referencia = '0;
   logic [N_CH*W-1:0]   y_k = '0;
   logic [N_CH*W-1:0]   salida_IPD, prop, integral, derivativa;
   logic [N_CH-1:0]     sat_flag;
   logic                ocupado, listo;

   int compared   = 0;
   int mismatched = 0;
   int lat, pulses, firstSeen;

   ipd_multicanal #(.W(W), .F(F), .N_CH(N_CH)) dut (
      .clock(clock), .reset(reset), .enable(enable), .modo(modo),
      .kp(kp), .ki(ki), .kd(kd),
      .referencia(referencia), .y_k(y_k),
      .salida_IPD(salida_IPD), .prop(prop), .integral(integral),
      .derivativa(derivativa), .sat_flag(sat_flag),
      .ocupado(ocupado), .listo(listo)
   );

   always #5 clock = ~clock;

   function automatic logic [W-1:0] q8(input int v);
      return W'(v * 256);
   endfunction

   function automatic logic [W-1:0] fld(input logic [N_CH*W-1:0] v, input int c);
      return v[c*W +: W];
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launches one sample on the next negedge and returns the listo latency in edges.
   task automatic applyStimulus(input int r0, input int y0, input int r1, input int y1,
                                output int latency);
      @(negedge clock);
      referencia = {q8(r1), q8(r0)};
      y_k        = {q8(y1), q8(y0)};
      enable     = 1'b1;
      @(negedge clock);
      enable  = 1'b0;
      latency = -1;
      for (int n = 1; n <= 40 && latency < 0; n++) begin
         @(negedge clock);
         if (listo) latency = n;
      end
   endtask

   task automatic pulseReset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rst_u0", fld(salida_IPD, 0), '0);
      checkOutput("rst_u1", fld(salida_IPD, 1), '0);
      checkOutput("rst_prop0", fld(prop, 0), '0);
      checkOutput("rst_int0", fld(integral, 0), '0);
      checkOutput("rst_der0", fld(derivativa, 0), '0);
      checkOutput("rst_sat", W'(sat_flag), '0);
      checkOutput("rst_busy", W'(ocupado), '0);
      checkOutput("rst_listo", W'(listo), '0);

      // I-PD, first sample then a step in y
      modo = 1'b0; kp = q8(1); ki = 19'd128; kd = q8(2);
      applyStimulus(100, 0, 0, 0, lat);
      checkOutput("ipd1_lat", W'(lat), W'(9));
      checkOutput("ipd1_u0", fld(salida_IPD, 0), q8(50));
      checkOutput("ipd1_int0", fld(integral, 0), q8(50));
      checkOutput("ipd1_der0", fld(derivativa, 0), '0);
      checkOutput("ipd1_u1", fld(salida_IPD, 1), '0);
      @(negedge clock);
      checkOutput("ipd1_listo_off", W'(listo), '0);
      checkOutput("ipd1_busy_off", W'(ocupado), '0);
      applyStimulus(100, 10, 0, 0, lat);
      checkOutput("ipd2_int0", fld(integral, 0), q8(95));
      checkOutput("ipd2_prop0", fld(prop, 0), q8(-10));
      checkOutput("ipd2_der0", fld(derivativa, 0), q8(-20));
      checkOutput("ipd2_u0", fld(salida_IPD, 0), q8(65));
      checkOutput("ipd2_sat0", W'(sat_flag[0]), '0);

      // Saturation and anti-windup
      pulseReset();
      modo = 1'b0; kp = '0; ki = q8(1); kd = '0;
      applyStimulus(1000, 0, 0, 0, lat);
      checkOutput("aw1_u0", fld(salida_IPD, 0), q8(1000));
      checkOutput("aw1_sat0", W'(sat_flag[0]), '0);
      applyStimulus(1000, 0, 0, 0, lat);
      checkOutput("aw2_u0", fld(salida_IPD, 0), 19'h3FFFF);
      checkOutput("aw2_sat0", W'(sat_flag[0]), W'(1));
      applyStimulus(1000, 0, 0, 0, lat);
      checkOutput("aw3_int0", fld(integral, 0), 19'h3FFFF);
      checkOutput("aw3_u0", fld(salida_IPD, 0), 19'h3FFFF);
      applyStimulus(0, 0, 0, 0, lat);
      checkOutput("aw4_int0_held", fld(integral, 0), q8(1000));
      checkOutput("aw4_sat0", W'(sat_flag[0]), '0);

      // Enable while busy is ignored
      @(negedge clock);
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      checkOutput("busy_start", W'(ocupado), W'(1));
      pulses = 0; firstSeen = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (listo) begin
            pulses++;
            if (firstSeen < 0) firstSeen = n;
         end
         if (n == 2) enable = 1'b1;
         if (n == 3) enable = 1'b0;
      end
      checkOutput("ign_pulses", W'(pulses), W'(1));
      checkOutput("ign_first", W'(firstSeen), W'(9));
      checkOutput("ign_busy_end", W'(ocupado), '0);

      // Reset during MUL_I of channel 1 aborts the sample
      modo = 1'b0; kp = q8(1); ki = '0; kd = q8(1);
      applyStimulus(0, 8, 0, 8, lat);
      checkOutput("pre_prop0", fld(prop, 0), q8(-8));
      @(negedge clock);
      y_k = {q8(2), q8(2)};
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      pulses = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clock);
         if (listo) pulses++;
         if (n == 6) reset = 1'b0;
      end
      repeat (2) @(negedge clock);
      checkOutput("abort_u0", fld(salida_IPD, 0), '0);
      checkOutput("abort_u1", fld(salida_IPD, 1), '0);
      checkOutput("abort_prop0", fld(prop, 0), '0);
      checkOutput("abort_der1", fld(derivativa, 1), '0);
      checkOutput("abort_busy", W'(ocupado), '0);
      reset = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         if (listo) pulses++;
      end
      checkOutput("abort_no_listo", W'(pulses), '0);
      applyStimulus(0, 4, 0, 4, lat);
      checkOutput("post_lat", W'(lat), W'(9));
      checkOutput("post_der0", fld(derivativa, 0), '0);
      checkOutput("post_der1", fld(derivativa, 1), '0);
      checkOutput("post_prop0", fld(prop, 0), q8(-4));
      checkOutput("post_u0", fld(salida_IPD, 0), q8(-4));

      // PID mode, independent channels
      pulseReset();
      modo = 1'b1; kp = q8(1); ki = '0; kd = '0;
      applyStimulus(20, 5, 100, 40, lat);
      checkOutput("pid_prop1", fld(prop, 1), q8(60));
      checkOutput("pid_u1", fld(salida_IPD, 1), q8(60));
      checkOutput("pid_prop0", fld(prop, 0), q8(15));
      checkOutput("pid_u0", fld(salida_IPD, 0), q8(15));
      applyStimulus(20, 5, 50, 0, lat);
      checkOutput("pid2_u1", fld(salida_IPD, 1), q8(50));
      checkOutput("pid2_u0", fld(salida_IPD, 0), q8(15));
      checkOutput("pid2_int1", fld(integral, 1), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ipd_multicanal.md
IPD_MULTICANAL -- requirements
Module: ipd_multicanal

Interface
REQ-001 Parameter W, 19, signal width in bits, signed two's complement.
REQ-002 Parameter F, 8, fractional bits; all signals and gains are Q(W-F).F.
REQ-003 Parameter N_CH, 2, number of independent control channels (1..8).
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-006 enable  in  1  start-of-sample request; sampled only in IDLE.
REQ-007 modo  in  1  0 = I-PD (P and D act on y), 1 = PID (P and D act on error).
REQ-008 kp, ki, kd  in  W each  shared signed gains, latched at start.
REQ-009 referencia  in  N_CH*W  packed references; channel c at bits [c*W +: W].
REQ-010 y_k  in  N_CH*W  packed plant outputs, same packing.
REQ-011 salida_IPD  out  N_CH*W  packed saturated control outputs.
REQ-012 prop, integral, derivativa  out  N_CH*W each  packed per-term values of the last sample.
REQ-013 sat_flag  out  N_CH  1 = channel output saturated on the last sample.
REQ-014 ocupado  out  1  high from the start edge until listo.
REQ-015 listo  out  1  one-cycle pulse when all channels are updated.

Function
REQ-016 FSM states: IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUMA; MUL_P..SUMA repeat per channel, c = 0..N_CH-1.
REQ-017 IDLE with enable=1: latch referencia, y_k, gains, modo; go to LOAD; ocupado=1.
REQ-018 LOAD: compute e_c = r_c - y_c (W+1 bits) for channel 0 and set the channel index; then go to MUL_P.
REQ-019 One shared signed multiplier W x (W+1); product arithmetic-shifted right by F (floor); one product per MUL_* state.
REQ-020 I-PD: P = -kp*y, D = -kd*(y - y_prev); PID: P = kp*e, D = kd*(e - e_prev); both: Itmp = I_prev + ki*e.
REQ-021 SUMA: u = Itmp + P + D in W+3 bits, saturated to [-2^(W-1), 2^(W-1)-1]; sat_flag_c = 1 if clipped.
REQ-022 Integral saturates independently to the same range.
REQ-023 Anti-windup: if u clipped high and ki*e > 0, or clipped low and ki*e < 0, I_prev is held, not updated.
REQ-024 SUMA also stores y_prev_c and e_prev_c and writes channel c outputs; the FSM then advances to the next channel's MUL_P, or to IDLE after the last channel.
REQ-025 Latency: listo=1 for exactly one cycle, 4*N_CH+1 edges after the enable sampling edge; ocupado drops on the same edge.
REQ-026 enable is ignored while ocupado=1; no queuing.
REQ-027 First sample after reset, per channel: D = 0 and y_prev/e_prev are loaded; this prevents a derivative kick.
REQ-028 Outputs hold their values between samples; only the active channel's fields change in its SUMA.

Reset
REQ-029 When reset=0: all outputs, integrators, y_prev, e_prev and the multiplier pipeline clear to 0, the first-sample flags are set, and the FSM goes to IDLE.
REQ-030 Reset mid-sample aborts the sample: no listo pulse and no partial channel update survives; operation resumes on the first enable after reset rises.

Verification (W=19, F=8, N_CH=2; values written as real, Q-encoded ×256)
REQ-031 Release reset -> all outputs 0, ocupado=0, listo=0.
REQ-032 modo=0, kp=1.0, ki=0.5, kd=2.0, r0=100, y0=0 -> u0=50 (12800); next sample y0=10 -> I=95, P=-10, D=-20, u0=65.
REQ-033 kp=kd=0, ki=1.0, r0=1000, y0=0 -> sample 1 u0=1000; sample 2 u0=0x3FFFF with sat_flag0=1; sample 3 integral stays 0x3FFFF (windup held).
REQ-034 enable pulsed at start edge and again 3 cycles later -> exactly one listo, 9 cycles after the start edge.
REQ-035 reset=0 during MUL_I of channel 1 -> no listo, all outputs 0; next sample is treated as first (derivativa = 0).
REQ-036 modo=1, kp=1.0, ki=kd=0, r1=100, y1=40 -> prop1 = 60, u1 = 60; channel 0 results are independent of channel 1.
